// File: rtl/sr_imem_loader.sv
// Instruction RAM for sr_cpu with a byte-serial program loader.
// Bytes are packed little-endian into words; the core is held in reset until the image is in.
module sr_imem_loader #(
   parameter int          ADDR_W    = 8,
   parameter logic [31:0] OOR_INSTR = 32'h00000013
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_start,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [7:0]        ld_byte,
   input  logic              ld_last,
   output logic              ld_done,
   output logic              ld_err,
   output logic [ADDR_W:0]   word_count,
   output logic              cpu_rst,
   input  logic [31:0]       instr_addr,
   output logic [31:0]       instr_data
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [1:0] {IDLE, LOAD, PAD, RUN} stateT;

   stateT             state;
   stateT             nextState;
   logic [1:0]        byteIdx;
   logic [31:0]       asmWord;
   logic [ADDR_W:0]   wordPtr;
   logic              accept;
   logic              wordWrite;
   logic [31:0]       writeData;
   logic              memWe;
   logic              startLoad;
   logic [31:0]       mem [DEPTH];

   assign accept     = ld_valid & ld_ready;
   assign startLoad  = ld_start & ((state == IDLE) | (state == RUN));
   assign memWe      = rst & wordWrite & (wordPtr != FULL);
   assign word_count = wordPtr;

   // Next state plus the word-completion event, which comes either from the
   // fourth byte of a word or from the single flush cycle of a short tail.
   always_comb begin
      nextState = state;
      wordWrite = 1'b0;
      writeData = asmWord;
      case (state)
         IDLE: if (ld_start) nextState = LOAD;
         LOAD: begin
            if (accept && byteIdx == 2'd3) begin
               wordWrite = 1'b1;
               writeData = {ld_byte, asmWord[23:0]};
            end
            if (accept && ld_last) nextState = (byteIdx == 2'd3) ? RUN : PAD;
         end
         PAD: begin
            wordWrite = 1'b1;
            nextState = RUN;
         end
         RUN: if (ld_start) nextState = LOAD;
         default: nextState = IDLE;
      endcase
   end

   // Handshake and core-reset outputs are registered from the next state so
   // they change together with the state they describe.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         cpu_rst  <= 1'b1;
         ld_ready <= 1'b0;
         ld_done  <= 1'b0;
      end else begin
         state    <= nextState;
         cpu_rst  <= (nextState != RUN);
         ld_ready <= (nextState == LOAD);
         ld_done  <= (nextState == RUN);
      end
   end

   // Byte assembly and word pointer; a full pointer turns further words into
   // a sticky error while the stream keeps draining.
   always_ff @(posedge clk) begin
      if (!rst) begin
         byteIdx <= 2'd0;
         asmWord <= 32'd0;
         wordPtr <= '0;
         ld_err  <= 1'b0;
      end else if (startLoad) begin
         byteIdx <= 2'd0;
         asmWord <= 32'd0;
         wordPtr <= '0;
         ld_err  <= 1'b0;
      end else begin
         if (accept) begin
            if (byteIdx == 2'd3) begin
               byteIdx <= 2'd0;
               asmWord <= 32'd0;
            end else begin
               asmWord[{byteIdx, 3'b000} +: 8] <= ld_byte;
               byteIdx <= byteIdx + 2'd1;
            end
         end
         if (state == PAD) begin
            byteIdx <= 2'd0;
            asmWord <= 32'd0;
         end
         if (wordWrite) begin
            if (wordPtr == FULL) ld_err  <= 1'b1;
            else                 wordPtr <= wordPtr + 1'b1;
         end
      end
   end

   // RAM contents survive reset so a partially loaded image stays visible.
   always_ff @(posedge clk) begin
      if (memWe) mem[wordPtr[ADDR_W-1:0]] <= writeData;
   end

   always_comb begin
      instr_data = OOR_INSTR;
      if (instr_addr[31:ADDR_W] == '0) instr_data = mem[instr_addr[ADDR_W-1:0]];
   end

endmodule
